regfile_dump_reader: RTL and testbench
======================================

# regfile_dump_reader

Sequential read-side master for the processor's 32x32 register file. On a start pulse it walks register indices FIRST_REG..NUM_REGS-1 through one combinational read port and streams each value out over a valid/ready interface. It sits beside the core's register file, driving a read address (rs-style port), and feeds a debug/UART/testbench sink for architectural state dumps.

## Interface
- NUM_REGS, 32, number of registers walked; last index is NUM_REGS-1
- FIRST_REG, 0, first index emitted; must be less than NUM_REGS
- ADDR_W, 5, register index width
- DATA_W, 32, register data width
- clk  input  1  rising-edge clock; one clock for the whole block
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a dump; sampled only in IDLE
- abort  input  1  terminate dump; sampled in READ/HOLD
- rd_addr  output  ADDR_W  read index to register file read port
- rd_data  input  DATA_W  combinational read data from register file for rd_addr
- out_valid  output  1  out_data/out_index hold a word
- out_ready  input  1  sink accepts the word when high with out_valid
- out_data  output  DATA_W  captured register value
- out_index  output  ADDR_W  index of out_data
- busy  output  1  high in READ, HOLD, DONE
- done  output  1  one-cycle pulse after the last word is accepted or on abort

## Operation
- States: IDLE, READ, HOLD, DONE. Internal index counter idx (ADDR_W bits).
- IDLE: rd_addr=0, out_valid=0, busy=0. start=1 -> idx<=FIRST_REG, go READ. start while not IDLE is ignored.
- READ: rd_addr=idx. At the clock edge: out_data<=rd_data, out_index<=idx, out_valid<=1, go HOLD.
- HOLD: out_valid=1; out_data/out_index stable until accepted. rd_addr keeps idx. out_valid&out_ready at edge: out_valid<=0; if idx==NUM_REGS-1 go DONE, else idx<=idx+1, go READ.
- DONE: done=1 for exactly one cycle, out_valid=0; next edge -> IDLE. busy=1 in DONE.
- abort=1 in READ or HOLD (priority over handshake): out_valid<=0, no word accepted that edge, go DONE. abort in IDLE/DONE ignored.
- Captured value is register contents at the READ cycle; a write to the same index committing at that same edge is not visible (write lands at the edge, read is before it).
- idx never wraps: the terminal compare at NUM_REGS-1 ends the walk; no increment past it.
- Block never drives the write port; x0 is emitted as whatever rd_data returns (0 from the register file).

## Timing
- Reset values: state IDLE, idx=0, rd_addr=0, out_valid=0, out_data=0, out_index=0, busy=0, done=0. Reset mid-dump returns to IDLE in one edge, no done pulse.
- start sampled high at edge E0 -> READ during cycle after E0 (busy=1); out_valid=1 after E1.
- Per-word cost: 2 cycles minimum (READ + HOLD) with out_ready held high.
- Full dump, FIRST_REG=0, out_ready=1: last accept at edge E64; done=1 during cycle after E64; IDLE after E65.
- out_ready low stalls HOLD indefinitely; out_valid never drops without acceptance, abort, or reset.
- start high in the DONE cycle ignored; new start accepted in IDLE the cycle after.

## Test plan
- Bench: register_files with power-up image (x1=3, x12=90, x31=10). reset 2 cycles -> all outputs 0; start 1 cycle, out_ready=1 -> 32 words index 0..31, out_data[0]=0, [1]=3, [12]=90, [31]=10; done pulses once at cycle 65 after start.
- Backpressure: out_ready toggled pseudo-randomly -> out_data/out_index stable while out_valid&!out_ready; same 32-word sequence, no drops/duplicates.
- Write race: write x5<=99 at the edge ending READ for index 5 -> word 5 = 3 (old); rerun dump -> word 5 = 99.
- Abort: assert abort in HOLD at index 7 with out_ready=0 -> no word 7 accepted, out_valid=0 next cycle, done=1 one cycle, then IDLE; start again -> full dump from 0.
- Reset mid-dump at index 20 -> next cycle state IDLE, out_valid=0, busy=0, done never pulses; start ignored while busy (pulse start at index 3 -> sequence unchanged).
- FIRST_REG=28 -> exactly 4 words (28..31 = 12,34,5,10), done after 4th accept.

Source files
------------

// File: rtl/regfile_dump_reader.sv
// Sequential register-file dump master: walks indices FIRST_REG..NUM_REGS-1
// through a combinational read port and streams each word out over valid/ready.
module regfile_dump_reader #(
  parameter int NUM_REGS  = 32,
  parameter int FIRST_REG = 0,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_next;
  logic              r_out_valid;
  logic              w_out_valid_next;
  logic [DATA_W-1:0] r_out_data;
  logic [ADDR_W-1:0] r_out_index;
  logic              w_capture;

  always_comb begin
    w_state_next     = r_state;
    w_idx_next       = r_idx;
    w_out_valid_next = r_out_valid;
    w_capture        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_idx_next   = FIRST_IDX;
          w_state_next = S_READ;
        end
      end
      S_READ: begin
        if (abort) begin
          w_out_valid_next = 1'b0;
          w_state_next     = S_DONE;
        end else begin
          w_capture        = 1'b1;
          w_out_valid_next = 1'b1;
          w_state_next     = S_HOLD;
        end
      end
      S_HOLD: begin
        // abort outranks the handshake: the held word is dropped, not accepted
        if (abort) begin
          w_out_valid_next = 1'b0;
          w_state_next     = S_DONE;
        end else if (out_ready) begin
          w_out_valid_next = 1'b0;
          if (r_idx == LAST_IDX) begin
            w_state_next = S_DONE;
          end else begin
            w_idx_next   = r_idx + ADDR_W'(1);
            w_state_next = S_READ;
          end
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_out_valid <= w_out_valid_next;
      if (w_capture) begin
        r_out_data  <= rd_data;
        r_out_index <= r_idx;
      end
    end
  end

  assign rd_addr   = (r_state == S_READ || r_state == S_HOLD) ? r_idx : '0;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: full walk, backpressure, write race,
// abort, reset mid-dump, and a FIRST_REG=28 instance sharing one register file.
module tb_regfile_dump_reader;

  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start_a, abort_a, start_b;
  logic [AW-1:0] rd_addr_a, rd_addr_b, out_index_a, out_index_b;
  logic [DW-1:0] rd_data_a, rd_data_b, out_data_a, out_data_b;
  logic          out_valid_a, out_valid_b, busy_a, busy_b, done_a, done_b;
  logic          ready_a = 1'b1;
  logic          ready_b = 1'b1;
  logic          abort_b = 1'b0;

  logic [DW-1:0] mem [32];
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [DW-1:0] img [32];

  always @(posedge clk) if (we) mem[wa] <= wd;
  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

  regfile_dump_reader #(.NUM_REGS(32), .FIRST_REG(0), .ADDR_W(AW), .DATA_W(DW)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .out_valid(out_valid_a),
    .out_ready(ready_a), .out_data(out_data_a), .out_index(out_index_a),
    .busy(busy_a), .done(done_a));

  regfile_dump_reader #(.NUM_REGS(32), .FIRST_REG(28), .ADDR_W(AW), .DATA_W(DW)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .out_valid(out_valid_b),
    .out_ready(ready_b), .out_data(out_data_b), .out_index(out_index_b),
    .busy(busy_b), .done(done_b));

  typedef struct {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ready pattern for instance A: 0 = always high, 1 = random, 2 = low only while holding stop_idx
  int mode_a = 0;
  int stop_idx = 0;
  always @(posedge clk) begin
    #1;
    case (mode_a)
      0:       ready_a = 1'b1;
      1:       ready_a = 1'($urandom_range(0, 1));
      default: ready_a = !(out_valid_a && out_index_a == AW'(stop_idx));
    endcase
  end

  logic          hold_a = 1'b0;
  logic [AW-1:0] p_idx_a;
  logic [DW-1:0] p_data_a;
  exp_t          e_a;
  always @(negedge clk) begin
    if (out_valid_a) begin
      if (hold_a) begin
        chk("a_stall_index_stable", 64'(out_index_a), 64'(p_idx_a));
        chk("a_stall_data_stable", 64'(out_data_a), 64'(p_data_a));
      end
      if (ready_a) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_word", 64'(out_index_a), 64'hFFFF);
        end else begin
          e_a = qa.pop_front();
          chk("a_word_index", 64'(out_index_a), 64'(e_a.idx));
          chk("a_word_data", 64'(out_data_a), 64'(e_a.data));
        end
      end
    end
    hold_a   = out_valid_a && !ready_a;
    p_idx_a  = out_index_a;
    p_data_a = out_data_a;
  end

  exp_t e_b;
  always @(negedge clk) begin
    if (out_valid_b && ready_b) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_word", 64'(out_index_b), 64'hFFFF);
      end else begin
        e_b = qb.pop_front();
        chk("b_word_index", 64'(out_index_b), 64'(e_b.idx));
        chk("b_word_data", 64'(out_data_b), 64'(e_b.data));
      end
    end
  end

  task automatic push_exp(input bit b, input int lo, input int hi);
    exp_t e;
    for (int i = lo; i <= hi; i++) begin
      e.idx  = AW'(i);
      e.data = img[i];
      if (b) qb.push_back(e);
      else   qa.push_back(e);
    end
  endtask

  task automatic pulse_start(input bit b);
    @(posedge clk); #1;
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // cyc = posedges after the start-sampling edge before done is observed
  task automatic wait_done(input bit b, input bit poke_start, output int cyc);
    bit found = 1'b0;
    cyc = -1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (b ? done_b : done_a) begin
        found = 1'b1;
        cyc = n;
        break;
      end
      @(posedge clk);
    end
    chk("done_seen", 64'(found), 64'd1);
    chk("busy_in_done", 64'(b ? busy_b : busy_a), 64'd1);
    chk("valid_low_in_done", 64'(b ? out_valid_b : out_valid_a), 64'd0);
    if (poke_start) start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("done_one_cycle", 64'(b ? done_b : done_a), 64'd0);
    chk("idle_after_done", 64'(b ? busy_b : busy_a), 64'd0);
  endtask

  task automatic wait_hold_a(input int idx, input string nm);
    bit found = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (out_valid_a && out_index_a == AW'(idx)) begin
        found = 1'b1;
        break;
      end
    end
    chk(nm, 64'(found), 64'd1);
  endtask

  int cyc;
  int dcount;
  bit race_found;

  initial begin
    reset = 1'b1; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0;
    we = 1'b0; wa = '0; wd = '0;

    img[0] = '0;
    for (int i = 1; i < 32; i++) img[i] = $urandom;
    img[1] = 32'd3;  img[5] = 32'd3;  img[12] = 32'd90;
    img[28] = 32'd12; img[29] = 32'd34; img[30] = 32'd5; img[31] = 32'd10;

    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; wa = AW'(i); wd = img[i];
      @(posedge clk); #1;
    end
    we = 1'b0;

    @(negedge clk);
    chk("rst_rd_addr", 64'(rd_addr_a), 64'd0);
    chk("rst_out_valid", 64'(out_valid_a), 64'd0);
    chk("rst_out_data", 64'(out_data_a), 64'd0);
    chk("rst_out_index", 64'(out_index_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_b_valid", 64'(out_valid_b), 64'd0);
    chk("rst_b_busy", 64'(busy_b), 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // full walk, ready high; start poked during DONE must be ignored
    mode_a = 0;
    push_exp(0, 0, 31);
    pulse_start(0);
    wait_done(0, 1'b1, cyc);
    chk("full_done_latency", 64'(cyc), 64'd64);
    chk("full_queue_empty", 64'(qa.size()), 64'd0);

    // random backpressure
    mode_a = 1;
    push_exp(0, 0, 31);
    pulse_start(0);
    wait_done(0, 1'b0, cyc);
    chk("bp_queue_empty", 64'(qa.size()), 64'd0);
    mode_a = 0;

    // write to x5 commits on the edge that ends READ of index 5: old value captured
    push_exp(0, 0, 31);
    pulse_start(0);
    fork
      begin
        race_found = 1'b0;
        for (int n = 0; n < 400; n++) begin
          @(negedge clk);
          if (busy_a && !out_valid_a && !done_a && rd_addr_a == AW'(5)) begin
            race_found = 1'b1;
            break;
          end
        end
        chk("race_window_found", 64'(race_found), 64'd1);
        we = 1'b1; wa = AW'(5); wd = 32'd99;
        @(posedge clk); #1 we = 1'b0;
      end
      wait_done(0, 1'b0, cyc);
    join
    chk("race_queue_empty", 64'(qa.size()), 64'd0);
    img[5] = 32'd99;
    push_exp(0, 0, 31);
    pulse_start(0);
    wait_done(0, 1'b0, cyc);
    chk("rerun_queue_empty", 64'(qa.size()), 64'd0);

    // abort while holding index 7 with ready low
    mode_a = 2; stop_idx = 7;
    push_exp(0, 0, 6);
    pulse_start(0);
    wait_hold_a(7, "abort_hold7_reached");
    abort_a = 1'b1;
    @(posedge clk); #1 abort_a = 1'b0;
    @(negedge clk);
    chk("abort_valid_dropped", 64'(out_valid_a), 64'd0);
    chk("abort_done_pulse", 64'(done_a), 64'd1);
    @(negedge clk);
    chk("abort_done_cleared", 64'(done_a), 64'd0);
    chk("abort_idle", 64'(busy_a), 64'd0);
    chk("abort_queue_empty", 64'(qa.size()), 64'd0);
    mode_a = 0;
    push_exp(0, 0, 31);
    pulse_start(0);
    wait_done(0, 1'b0, cyc);
    chk("post_abort_latency", 64'(cyc), 64'd64);
    chk("post_abort_queue_empty", 64'(qa.size()), 64'd0);

    // start ignored while busy, then reset while holding index 20
    mode_a = 2; stop_idx = 20;
    push_exp(0, 0, 19);
    pulse_start(0);
    wait_hold_a(3, "busy_hold3_reached");
    start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    wait_hold_a(20, "reset_hold20_reached");
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 64'(out_valid_a), 64'd0);
    chk("midrst_busy", 64'(busy_a), 64'd0);
    chk("midrst_done", 64'(done_a), 64'd0);
    chk("midrst_rd_addr", 64'(rd_addr_a), 64'd0);
    dcount = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (done_a) dcount++;
    end
    chk("midrst_no_done", 64'(dcount), 64'd0);
    chk("midrst_queue_empty", 64'(qa.size()), 64'd0);
    mode_a = 0;

    // FIRST_REG=28 instance: four words then done
    push_exp(1, 28, 31);
    pulse_start(1);
    wait_done(1, 1'b0, cyc);
    chk("b_done_latency", 64'(cyc), 64'd8);
    chk("b_queue_empty", 64'(qb.size()), 64'd0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
